mem_port_arbiter: RTL and testbench

//   Shares one single-port synchronous memory between the pipeline's instruction-fetch

---
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port synchronous memory between the fetch (IF) and
// data (DM) ports: one transaction at a time, DM priority with an IF anti-starvation limit.
`timescale 1ns/1ps

module mem_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam int              SW   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [2:0]      LAT  = 3'(MEM_LAT);
  localparam logic [SW-1:0]   SMAX = SW'(STARVE_MAX);

  state_t        state;
  logic [2:0]    lat_cnt;
  logic [SW-1:0] starve_cnt;
  logic          pick_if;

  // IF wins when it is alone, or when DM has already been favoured STARVE_MAX times in a row.
  assign pick_if = if_req & (~dm_req | (starve_cnt >= SMAX));

  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;
  assign if_rdata = if_done ? mem_rdata : '0;
  assign dm_rdata = dm_done ? mem_rdata : '0;

  // NOTE: every register below is assigned with <= so all of them update from the
  // same pre-edge values; a blocking = here would let later statements see new state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      if_gnt     <= 1'b0;
      dm_gnt     <= 1'b0;
      if_done    <= 1'b0;
      dm_done    <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      mem_en  <= 1'b0;
      if_done <= 1'b0;
      dm_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (if_req | dm_req) begin
            state  <= ISSUE;
            mem_en <= 1'b1;
            if_gnt <= pick_if;
            dm_gnt <= ~pick_if;
            if (pick_if) begin
              mem_addr   <= if_addr;
              mem_we     <= 1'b0;
              starve_cnt <= '0;
            end else begin
              mem_addr  <= dm_addr;
              mem_we    <= dm_we;
              mem_wdata <= dm_wdata;
              if (if_req && (starve_cnt < SMAX)) starve_cnt <= starve_cnt + 1'b1;
            end
          end
        end
        ISSUE: begin
          state   <= WAIT;
          lat_cnt <= 3'd1;
          // done is registered one cycle early so it lines up with mem_rdata.
          if (LAT == 3'd1) begin
            if_done <= if_gnt;
            dm_done <= dm_gnt;
          end
        end
        WAIT: begin
          if (lat_cnt == LAT) begin
            state  <= IDLE;
            if_gnt <= 1'b0;
            dm_gnt <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
            if ((lat_cnt + 3'd1) == LAT) begin
              if_done <= if_gnt;
              dm_done <= dm_gnt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: queue scoreboard for read data, a transaction-level
// arbitration/timing model for the MEM_LAT=1 instance, directed checks on a MEM_LAT=3 instance.
`timescale 1ns/1ps

module tb_mem_port_arbiter;

  localparam int AW = 10, DW = 64, LAT = 1, LAT3 = 3, SMAX = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // MEM_LAT = 1 instance
  logic          if_req, if_gnt, if_done, if_stall;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we, dm_gnt, dm_done, dm_stall;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  // MEM_LAT = 3 instance
  logic          if_req3, if_gnt3, if_done3, if_stall3;
  logic [AW-1:0] if_addr3;
  logic [DW-1:0] if_rdata3;
  logic          dm_req3, dm_we3, dm_gnt3, dm_done3, dm_stall3;
  logic [AW-1:0] dm_addr3;
  logic [DW-1:0] dm_wdata3, dm_rdata3;
  logic          mem_en3, mem_we3;
  logic [AW-1:0] mem_addr3;
  logic [DW-1:0] mem_wdata3, mem_rdata3;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
    .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT3), .STARVE_MAX(SMAX)) u_dut3 (
    .clk(clk), .reset(reset),
    .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_done(if_done3),
    .if_rdata(if_rdata3), .if_stall(if_stall3),
    .dm_req(dm_req3), .dm_we(dm_we3), .dm_addr(dm_addr3), .dm_wdata(dm_wdata3),
    .dm_gnt(dm_gnt3), .dm_done(dm_done3), .dm_rdata(dm_rdata3), .dm_stall(dm_stall3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] init_word(input logic [9:0] a);
    return {16'hA5A5, 6'd0, a, 32'h0000_0093};
  endfunction

  function automatic logic [63:0] f3(input logic [9:0] a);
    return {32'h3333_0000, 22'd0, a};
  endfunction

  // Memory models. Read data is garbage outside its valid cycle so late/early done shows up.
  logic [DW-1:0] mem1 [0:1023];
  bit            mem_ready;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 1024; i++) mem1[i] <= init_word(10'(i));
      mem_ready <= 1'b1;
    end else if (mem_en && mem_we) begin
      mem1[mem_addr] <= mem_wdata;
    end
    mem_rdata <= (mem_en && !mem_we && mem_ready) ? mem1[mem_addr] : 64'hBADD_BADD_BADD_BADD;
  end

  logic [DW-1:0] rp3 [0:2];
  always @(posedge clk) begin
    rp3[0] <= mem_en3 ? f3(mem_addr3) : 64'hBADD_BADD_BADD_BADD;
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end
  assign mem_rdata3 = rp3[2];

  // Scoreboard: stimulus pushes expectations, the monitor pops on done.
  typedef struct {
    bit            we;
    logic [DW-1:0] data;
  } dm_exp_t;

  logic [DW-1:0] if_q [$];
  dm_exp_t       dm_q [$];
  logic [DW-1:0] ref_mem [0:1023];

  always @(negedge clk) begin : data_monitor
    logic [DW-1:0] e;
    dm_exp_t       d;
    if (reset) begin
      if (if_done) begin
        check_bit("if_q_nonempty", if_q.size() != 0, 1'b1);
        if (if_q.size() != 0) begin
          e = if_q.pop_front();
          check("if_rdata", if_rdata, e);
        end
      end
      if (dm_done) begin
        check_bit("dm_q_nonempty", dm_q.size() != 0, 1'b1);
        if (dm_q.size() != 0) begin
          d = dm_q.pop_front();
          if (!d.we) check("dm_rdata", dm_rdata, d.data);
        end
      end
    end
  end

  // Transaction-level model: who wins each arbitration, when mem_en/gnt/done must appear.
  bit            busy, owner_if, p_idle, p_if_req, p_dm_req, p_dm_we, exp_en, win_if, exp_done;
  int            since, streak;
  logic [AW-1:0] p_if_addr, p_dm_addr;
  logic [DW-1:0] p_dm_wdata;
  string         grant_str;

  always @(negedge clk) begin
    if (!reset) begin
      check_bit("rst_mem_en", mem_en, 1'b0);
      check_bit("rst_if_gnt", if_gnt, 1'b0);
      check_bit("rst_dm_gnt", dm_gnt, 1'b0);
      check_bit("rst_if_done", if_done, 1'b0);
      check_bit("rst_dm_done", dm_done, 1'b0);
      check_bit("rst_if_stall", if_stall, if_req);
      check_bit("rst_dm_stall", dm_stall, dm_req);
      busy = 1'b0; since = 0; streak = 0; p_idle = 1'b1;
      p_if_req = 1'b0; p_dm_req = 1'b0;
    end else begin
      if (busy) since++;
      exp_en = p_idle && (p_if_req || p_dm_req);
      check_bit("mem_en", mem_en, exp_en);
      if (exp_en) begin
        win_if = p_if_req && (!p_dm_req || streak >= SMAX);
        if (win_if) streak = 0;
        else if (p_if_req && streak < SMAX) streak++;
        busy = 1'b1; since = 0; owner_if = win_if;
        check("mem_addr", 64'(mem_addr), 64'(win_if ? p_if_addr : p_dm_addr));
        check_bit("mem_we", mem_we, win_if ? 1'b0 : p_dm_we);
        if (!win_if && p_dm_we) check("mem_wdata", mem_wdata, p_dm_wdata);
        if (if_gnt) grant_str = {grant_str, "I"};
        else        grant_str = {grant_str, "D"};
      end
      exp_done = busy && (since == LAT);
      check_bit("if_gnt", if_gnt, busy && owner_if);
      check_bit("dm_gnt", dm_gnt, busy && !owner_if);
      check_bit("if_done", if_done, exp_done && owner_if);
      check_bit("dm_done", dm_done, exp_done && !owner_if);
      check_bit("if_stall", if_stall, if_req && !(exp_done && owner_if));
      check_bit("dm_stall", dm_stall, dm_req && !(exp_done && !owner_if));
      p_idle = !busy;
      if (exp_done) busy = 1'b0;
      p_if_req = if_req;  p_if_addr = if_addr;
      p_dm_req = dm_req;  p_dm_addr = dm_addr;  p_dm_we = dm_we;  p_dm_wdata = dm_wdata;
    end
  end

  // Requester-side drivers: hold the command until done, then drop or re-present.
  task automatic if_txn(input logic [9:0] a, input int gap);
    int n;
    repeat (gap) begin @(posedge clk); #1; end
    if_addr = a;
    if_req  = 1'b1;
    if_q.push_back(init_word(a));
    n = 0;
    do begin @(negedge clk); n++; end while (!if_done && n < 100);
    check_bit("if_done_seen", if_done, 1'b1);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic dm_txn(input bit we, input logic [9:0] a, input logic [63:0] wd, input int gap);
    int n;
    repeat (gap) begin @(posedge clk); #1; end
    dm_we = we; dm_addr = a; dm_wdata = wd; dm_req = 1'b1;
    if (we) begin
      ref_mem[a] = wd;
      dm_q.push_back('{we: 1'b1, data: 64'd0});
    end else begin
      dm_q.push_back('{we: 1'b0, data: ref_mem[a]});
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!dm_done && n < 100);
    check_bit("dm_done_seen", dm_done, 1'b1);
    @(posedge clk); #1;
    dm_req = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int    dm_c, if_c, en_c, done_c, en_cnt;
    string exp_order;

    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(10'(i));
    reset = 1'b0;
    if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    if_req3 = 0; if_addr3 = '0; dm_req3 = 0; dm_we3 = 0; dm_addr3 = '0; dm_wdata3 = '0;

    // Stalls follow req combinationally while in reset.
    @(posedge clk); #1;
    dm_req = 1'b1;
    #1 check_bit("rst_stall_follows_req", dm_stall, 1'b1);
    check_bit("rst_gnt_low", dm_gnt, 1'b0);
    dm_req = 1'b0;
    #1 check_bit("rst_stall_drops", dm_stall, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Single fetch: mem_en in cycle 1, done + data in cycle 2.
    if_addr = 10'd5; if_req = 1'b1;
    if_q.push_back(init_word(10'd5));
    @(negedge clk);
    check_bit("t1_stall_c0", if_stall, 1'b1);
    check_bit("t1_no_en_c0", mem_en, 1'b0);
    @(negedge clk);
    check_bit("t1_en_c1", mem_en, 1'b1);
    check_bit("t1_stall_c1", if_stall, 1'b1);
    @(negedge clk);
    check_bit("t1_done_c2", if_done, 1'b1);
    check("t1_rdata_c2", if_rdata, init_word(10'd5));
    @(posedge clk); #1;
    if_req = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Simultaneous IF and DM: DM first, IF at the next arbitration.
    dm_c = -1; if_c = -1;
    fork
      if_txn(10'd600, 0);
      dm_txn(1'b0, 10'd8, 64'd0, 0);
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (dm_done) dm_c = k;
        if (if_done) if_c = k;
      end
    join
    check("t2_dm_done_cycle", 64'(dm_c), 64'd2);
    check("t2_if_done_cycle", 64'(if_c), 64'd5);
    repeat (2) begin @(posedge clk); #1; end

    // DM flood with IF pending: four DM grants, then IF, then the limit starts over.
    grant_str = "";
    fork
      begin
        if_txn(10'd700, 0);
        if_txn(10'd701, 0);
      end
      for (int i = 0; i < 10; i++) dm_txn(1'b0, 10'(100 + i), 64'd0, 0);
    join
    exp_order = "DDDDIDDDDIDD";
    check("t3_grant_count", 64'(grant_str.len()), 64'(exp_order.len()));
    for (int i = 0; i < exp_order.len() && i < grant_str.len(); i++)
      check("t3_grant_order", 64'(grant_str[i]), 64'(exp_order[i]));
    repeat (2) begin @(posedge clk); #1; end

    // Store then load back.
    dm_txn(1'b1, 10'd12, 64'h0000_0000_DEAD_BEEF, 0);
    dm_txn(1'b0, 10'd12, 64'd0, 0);
    check("t4_ref_store", ref_mem[12], 64'h0000_0000_DEAD_BEEF);

    // Randomised concurrent traffic; IF reads the upper half, DM owns the lower half.
    fork
      for (int i = 0; i < 40; i++)
        if_txn(10'(512 + $urandom_range(0, 511)), int'($urandom_range(0, 3)));
      for (int i = 0; i < 60; i++)
        dm_txn(1'($urandom_range(0, 1)), 10'($urandom_range(0, 511)),
               {$urandom, $urandom}, int'($urandom_range(0, 2)));
    join
    repeat (3) begin @(posedge clk); #1; end

    // MEM_LAT = 3: done exactly three cycles after the single mem_en.
    en_c = -1; done_c = -1; en_cnt = 0;
    dm_addr3 = 10'd40; dm_we3 = 1'b0; dm_req3 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (mem_en3) begin
        en_cnt++;
        if (en_c < 0) en_c = k;
        check_bit("t6_mem_we", mem_we3, 1'b0);
      end
      if (dm_done3 && done_c < 0) begin
        done_c = k;
        check("t6_rdata", dm_rdata3, f3(10'd40));
      end
    end
    @(posedge clk); #1;
    dm_req3 = 1'b0;
    check("t6_en_cycle", 64'(en_c), 64'd1);
    check("t6_done_cycle", 64'(done_c), 64'd4);
    check("t6_en_count", 64'(en_cnt), 64'd1);
    repeat (8) begin @(posedge clk); #1; end

    // Reset in WAIT abandons the fetch; the held req is re-arbitrated from IDLE.
    if_addr3 = 10'd7; if_req3 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_bit("t5_issue_en", mem_en3, 1'b1);
    @(negedge clk);
    check_bit("t5_wait_gnt", if_gnt3, 1'b1);
    check_bit("t5_wait_no_done", if_done3, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_bit("t5_rst_if_gnt", if_gnt3, 1'b0);
    check_bit("t5_rst_if_done", if_done3, 1'b0);
    check_bit("t5_rst_mem_en", mem_en3, 1'b0);
    check_bit("t5_rst_dm_gnt", dm_gnt3, 1'b0);
    check_bit("t5_rst_if_stall", if_stall3, 1'b1);
    check_bit("t5_rst_dm_stall", dm_stall3, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    en_c = -1; done_c = -1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (mem_en3 && en_c < 0) en_c = k;
      if (if_done3 && done_c < 0) begin
        done_c = k;
        check("t5_rdata", if_rdata3, f3(10'd7));
      end
    end
    @(posedge clk); #1;
    if_req3 = 1'b0;
    check("t5_reissue_cycle", 64'(en_c), 64'd1);
    check("t5_done_cycle", 64'(done_c), 64'd4);
    repeat (8) begin @(posedge clk); #1; end

    check_bit("if_q_drained", if_q.size() == 0, 1'b1);
    check_bit("dm_q_drained", dm_q.size() == 0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
